// File: rtl/rt_mon_pkg.sv
// Shared types, violation codes and the cause-priority helper for rt_get_monitor.
package rt_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_FAIL     = 2'd3
    } rt_mon_state_t;

    typedef logic [2:0] viol_code_t;

    localparam viol_code_t VIOL_NONE    = 3'd0;
    localparam viol_code_t VIOL_ERROR   = 3'd1;
    localparam viol_code_t VIOL_TIMEOUT = 3'd2;
    localparam viol_code_t VIOL_GAP     = 3'd3;
    localparam viol_code_t VIOL_OVER    = 3'd4;

    // Only the highest-priority cause is latched when several coincide.
    function automatic viol_code_t viol_pick(input logic err, input logic over,
                                             input logic tmo, input logic gap);
        viol_code_t code;
        code = VIOL_NONE;
        if (err) begin
            code = VIOL_ERROR;
        end else if (over) begin
            code = VIOL_OVER;
        end else if (tmo) begin
            code = VIOL_TIMEOUT;
        end else if (gap) begin
            code = VIOL_GAP;
        end
        return code;
    endfunction

endpackage

// File: rtl/rt_mon_timer.sv
// Loadable down-counter that holds at zero; zero flags the expired state.
module rt_mon_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rt_get_monitor.sv
// Bounded-response monitor for rt_get/response/error with a sticky encoded violation.
// Define RT_MON_GAP_CHECK_EN to add the post-grant cooldown and the GAP violation.
module rt_get_monitor #(
    parameter int MAX_LATENCY = 4,
    parameter int BUDGET      = 3,
    parameter int MIN_GAP     = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rt_get,
    input  logic             response,
    input  logic             error,
    output logic             pending,
    output logic [CNT_W-1:0] grants,
    output logic             budget_exhausted,
    output logic             rt_expire,
    output logic             violation,
    output logic [2:0]       viol_code
);
    import rt_mon_pkg::*;

    localparam int TMAX = (MAX_LATENCY > MIN_GAP) ? MAX_LATENCY : MIN_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    LAT_INIT = TW'(MAX_LATENCY - 1);
    localparam logic [CNT_W-1:0] BUDGET_C = CNT_W'(BUDGET);

    rt_mon_state_t    state_q, state_d;
    logic [CNT_W-1:0] grants_q, grants_d;
    logic             pending_q, pending_d;
    logic             exhausted_q, exhausted_d;
    logic             expire_q, expire_d;
    logic             violation_q, violation_d;
    viol_code_t       code_q, code_d;

    logic lat_load, lat_dec, lat_zero;
    logic err_c, over_c, tmo_c, gap_c, grant_c, fail_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x >= BUDGET_C) ? BUDGET_C : x + 1'b1;
    endfunction

    assign lat_dec = (state_q == ST_WAIT);

    rt_mon_timer #(.W(TW)) u_lat_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (lat_load),
        .dec   (lat_dec),
        .value (LAT_INIT),
        .zero  (lat_zero)
    );

`ifdef RT_MON_GAP_CHECK_EN
    localparam logic [TW-1:0] GAP_INIT = TW'(MIN_GAP - 1);

    logic gap_load, gap_dec, gap_zero;

    assign gap_dec = (state_q == ST_COOLDOWN);

    rt_mon_timer #(.W(TW)) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (gap_load),
        .dec   (gap_dec),
        .value (GAP_INIT),
        .zero  (gap_zero)
    );
`endif

    always_comb begin
        state_d     = state_q;
        grants_d    = grants_q;
        violation_d = violation_q;
        code_d      = code_q;
        expire_d    = 1'b0;
        lat_load    = 1'b0;
        tmo_c       = 1'b0;
        gap_c       = 1'b0;
        grant_c     = 1'b0;
`ifdef RT_MON_GAP_CHECK_EN
        gap_load    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rt_get && response) begin
                    grant_c = 1'b1;
                end else if (rt_get) begin
                    state_d  = ST_WAIT;
                    lat_load = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response on the zero cycle is still on time.
                if (response) begin
                    grant_c = 1'b1;
                end else if (lat_zero) begin
                    tmo_c    = 1'b1;
                    expire_d = 1'b1;
                end
            end
`ifdef RT_MON_GAP_CHECK_EN
            ST_COOLDOWN: begin
                if (rt_get) begin
                    gap_c = 1'b1;
                end else if (gap_zero) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: ;
        endcase

        err_c  = error && (state_q != ST_FAIL);
        over_c = grant_c && (grants_q == BUDGET_C);
        fail_c = err_c || over_c || tmo_c || gap_c;

        if (fail_c) begin
            state_d     = ST_FAIL;
            violation_d = 1'b1;
            code_d      = viol_pick(err_c, over_c, tmo_c, gap_c);
        end else if (grant_c) begin
            grants_d = sat_inc(grants_q);
`ifdef RT_MON_GAP_CHECK_EN
            state_d  = ST_COOLDOWN;
            gap_load = 1'b1;
`else
            state_d  = ST_IDLE;
`endif
        end

        pending_d   = (state_d == ST_WAIT);
        exhausted_d = (grants_d == BUDGET_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grants_q    <= '0;
            pending_q   <= 1'b0;
            exhausted_q <= 1'b0;
            expire_q    <= 1'b0;
            violation_q <= 1'b0;
            code_q      <= VIOL_NONE;
        end else begin
            state_q     <= state_d;
            grants_q    <= grants_d;
            pending_q   <= pending_d;
            exhausted_q <= exhausted_d;
            expire_q    <= expire_d;
            violation_q <= violation_d;
            code_q      <= code_d;
        end
    end

    assign pending          = pending_q;
    assign grants           = grants_q;
    assign budget_exhausted = exhausted_q;
    assign rt_expire        = expire_q;
    assign violation        = violation_q;
    assign viol_code        = code_q;

endmodule

// File: tb/tb_rt_get_monitor.sv
// Randomized and directed bench for rt_get_monitor against a cycle-arithmetic reference model.
module tb_rt_get_monitor;

    localparam int MAX_LATENCY = 4;
    localparam int BUDGET      = 3;
    localparam int MIN_GAP     = 2;
    localparam int CNT_W       = 4;
`ifdef RT_MON_GAP_CHECK_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, rt_get, response, error;
    logic             pending, budget_exhausted, rt_expire, violation;
    logic [CNT_W-1:0] grants;
    logic [2:0]       viol_code;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: cycle numbers instead of timers.
    int cyc = 0;
    int m_req_cyc = 0;
    int m_last_grant = -1000;
    int m_grants = 0;
    int m_code = 0;
    bit m_pend = 1'b0;
    bit m_fail = 1'b0;
    bit m_exp = 1'b0;

    rt_get_monitor #(
        .MAX_LATENCY (MAX_LATENCY),
        .BUDGET      (BUDGET),
        .MIN_GAP     (MIN_GAP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rt_get           (rt_get),
        .response         (response),
        .error            (error),
        .pending          (pending),
        .grants           (grants),
        .budget_exhausted (budget_exhausted),
        .rt_expire        (rt_expire),
        .violation        (violation),
        .viol_code        (viol_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit cooling, grant, newreq, f_err, f_over, f_tmo, f_gap;
        cyc++;
        m_exp = 1'b0;
        if (rst) begin
            m_fail = 1'b0; m_code = 0; m_grants = 0; m_pend = 1'b0;
            m_last_grant = -1000;
            return;
        end
        if (m_fail) return;
        grant = 1'b0; newreq = 1'b0; f_over = 1'b0; f_tmo = 1'b0; f_gap = 1'b0;
        f_err   = error;
        cooling = GAP_EN && ((cyc - m_last_grant) <= MIN_GAP);
        if (m_pend) begin
            if (response) grant = 1'b1;
            else if ((cyc - m_req_cyc) >= MAX_LATENCY) begin
                f_tmo = 1'b1;
                m_exp = 1'b1;
            end
        end else if (cooling) begin
            if (rt_get) f_gap = 1'b1;
        end else if (rt_get) begin
            if (response) grant = 1'b1;
            else newreq = 1'b1;
        end
        if (grant && (m_grants == BUDGET)) f_over = 1'b1;
        if (f_err || f_over || f_tmo || f_gap) begin
            m_fail = 1'b1;
            m_pend = 1'b0;
            m_code = f_err ? 1 : f_over ? 4 : f_tmo ? 2 : 3;
        end else begin
            if (grant) begin
                m_grants++;
                m_pend = 1'b0;
                m_last_grant = cyc;
            end
            if (newreq) begin
                m_pend = 1'b1;
                m_req_cyc = cyc;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pending", 32'(pending), 32'(m_pend));
            chk("grants", 32'(grants), 32'(m_grants));
            chk("budget_exhausted", 32'(budget_exhausted), 32'(m_grants == BUDGET));
            chk("rt_expire", 32'(rt_expire), 32'(m_exp));
            chk("violation", 32'(violation), 32'(m_fail));
            chk("viol_code", 32'(viol_code), 32'(m_code));
        end
    end

    task automatic drive(input bit g, input bit r, input bit e);
        rt_get = g; response = r; error = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        drive(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_grants"}, 32'(grants), 0);
        chk({tag, "_exhausted"}, 32'(budget_exhausted), 0);
        chk({tag, "_expire"}, 32'(rt_expire), 0);
        chk({tag, "_violation"}, 32'(violation), 0);
        chk({tag, "_code"}, 32'(viol_code), 0);
    endtask

    initial begin
        rst = 1'b1; rt_get = 1'b0; response = 1'b0; error = 1'b0;
        @(negedge clk);
        do_rst();
        chk_en = 1'b1;
        chk_all_zero("reset");

        // Immediate grants spaced by MIN_GAP idle cycles.
        drive(1, 1, 0);
        chk("imm_grants1", 32'(grants), 1);
        drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0);
        chk("imm_grants2", 32'(grants), 2);
        drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0);
        chk("imm_grants3", 32'(grants), 3);
        chk("imm_exhausted", 32'(budget_exhausted), 1);
        chk("imm_violation", 32'(violation), 0);
        chk("model_grants", 32'(m_grants), 3);

        // Fourth grant exceeds the budget.
        drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0);
        chk("over_violation", 32'(violation), 1);
        chk("over_code", 32'(viol_code), 4);
        chk("over_grants", 32'(grants), 3);
        chk("model_over_code", 32'(m_code), 4);

        // Timeout: expire pulse on the 4th edge after the request sample.
        do_rst();
        drive(1, 0, 0);
        chk("tmo_pending", 32'(pending), 1);
        for (int i = 0; i < MAX_LATENCY - 1; i++) begin
            drive(0, 0, 0);
            chk("tmo_no_expire_yet", 32'(rt_expire), 0);
        end
        drive(0, 0, 0);
        chk("tmo_expire", 32'(rt_expire), 1);
        chk("tmo_code", 32'(viol_code), 2);
        chk("tmo_pending_fall", 32'(pending), 0);
        drive(0, 0, 0);
        chk("tmo_expire_single", 32'(rt_expire), 0);

        // Deadline boundary: response on the last allowed cycle.
        do_rst();
        drive(1, 0, 0);
        for (int i = 0; i < MAX_LATENCY - 1; i++) drive(0, 0, 0);
        drive(0, 1, 0);
        chk("dl_grants", 32'(grants), 1);
        chk("dl_violation", 32'(violation), 0);
        chk("dl_pending", 32'(pending), 0);

        // Request right after a grant.
        do_rst();
        drive(1, 1, 0);
        drive(1, 0, 0);
        if (GAP_EN) begin
            chk("gap_code", 32'(viol_code), 3);
            chk("gap_violation", 32'(violation), 1);
        end else begin
            chk("nogap_pending", 32'(pending), 1);
            chk("nogap_violation", 32'(violation), 0);
        end

        // Error coinciding with the timeout edge: ERROR wins.
        do_rst();
        drive(1, 0, 0);
        for (int i = 0; i < MAX_LATENCY - 1; i++) drive(0, 0, 0);
        drive(0, 0, 1);
        chk("prio_code", 32'(viol_code), 1);
        chk("prio_violation", 32'(violation), 1);
        do_rst();
        chk_all_zero("prio_rst");
        drive(1, 1, 0);
        chk("prio_regrant", 32'(grants), 1);

        // Randomized traffic with occasional errors and resets.
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 199) < 3);
        end
        rst = 1'b0;
        drive(0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
